// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a first-word-fall-through FIFO and sends each one as a UART frame.
// The frame is a start bit, the data LSB first, an optional parity bit, then the stop bits.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  rd,
   output logic                  tx,
   output logic                  busy,
   output logic                  done_tick
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t                state_q;
   logic [TW-1:0]         tick_q, tick_d;
   logic [BW-1:0]         bit_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_q, tx_q;
   logic                  wrap, last_stop, load;
   assign wrap      = tick_q == TW'(CLKS_PER_BIT - 1);
   assign tick_d    = wrap ? '0 : tick_q + 1'b1;
   assign last_stop = (state_q == STOP) && wrap && (bit_q == BW'(STOP_BITS - 1));
   // A new word may be taken in the final stop cycle so frames run back to back.
   assign load      = en && !empty && ((state_q == IDLE) || last_stop);
   assign rd        = load;
   assign done_tick = last_stop;
   assign busy      = state_q != IDLE;
   assign tx        = tx_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else if (load) begin
         state_q <= START;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= r_data;
         par_q   <= (^r_data) ^ 1'(PARITY_ODD);
         tx_q    <= 1'b0;
      end else begin
         tick_q <= (state_q == IDLE) ? '0 : tick_d;
         case (state_q)
            START: if (wrap) begin
               state_q <= DATA;
               tx_q    <= shift_q[0];
            end
            DATA: if (wrap) begin
               shift_q <= shift_q >> 1;
               if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  bit_q   <= '0;
                  state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                  tx_q    <= (PARITY_EN != 0) ? par_q : 1'b1;
               end else begin
                  bit_q <= bit_q + 1'b1;
                  tx_q  <= shift_q[1];
               end
            end
            PARITY: if (wrap) begin
               state_q <= STOP;
               tx_q    <= 1'b1;
            end
            STOP: if (wrap) begin
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  bit_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  bit_q <= bit_q + 1'b1;
               end
            end
            default: tx_q <= 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx in 8N1, even/odd parity and two-stop-bit builds.
module tb_fifo_uart_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] en = '0, empty = '1;
   logic [7:0] rdat [4];
   logic [3:0] rd, tx, busy, done;
   int         rd_cnt [4] = '{default: 0};
   int         n_chk = 0, n_fail = 0;
   int         c0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(4)) u0 (.clk(clk), .reset(reset), .en(en[0]), .empty(empty[0]),
      .r_data(rdat[0]), .rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .done_tick(done[0]));
   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset),
      .en(en[1]), .empty(empty[1]), .r_data(rdat[1]), .rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .done_tick(done[1]));
   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .reset(reset),
      .en(en[2]), .empty(empty[2]), .r_data(rdat[2]), .rd(rd[2]), .tx(tx[2]), .busy(busy[2]), .done_tick(done[2]));
   fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (.clk(clk), .reset(reset),
      .en(en[3]), .empty(empty[3]), .r_data(rdat[3]), .rd(rd[3]), .tx(tx[3]), .busy(busy[3]), .done_tick(done[3]));

   always @(posedge clk)
      for (int i = 0; i < 4; i++) if (rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word already presented; bits[i] is the i-th bit on the line, nb bit periods of 4 clocks each.
   task automatic run_frame(input int k, input logic [11:0] bits, input int nb,
                            input bit more, input logic [7:0] nxt);
      #1 chk($sformatf("rd start k%0d", k), 8'(rd[k]), 8'd1);
      @(posedge clk);
      #1;
      empty[k] = ~more;
      rdat[k]  = nxt;
      for (int n = 1; n <= nb * 4; n++) begin
         @(negedge clk);
         chk($sformatf("tx k%0d n%0d", k, n), 8'(tx[k]), 8'(bits[(n - 1) / 4]));
         chk($sformatf("busy k%0d n%0d", k, n), 8'(busy[k]), 8'd1);
         chk($sformatf("done k%0d n%0d", k, n), 8'(done[k]), 8'(n == nb * 4));
         chk($sformatf("rd k%0d n%0d", k, n), 8'(rd[k]), 8'(more && n == nb * 4));
      end
      if (!more) begin
         @(negedge clk);
         chk($sformatf("idle busy k%0d", k), 8'(busy[k]), 8'd0);
         chk($sformatf("idle tx k%0d", k), 8'(tx[k]), 8'd1);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rdat[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset tx", 8'(tx[0]), 8'd1);
      chk("reset busy", 8'(busy[0]), 8'd0);
      chk("reset rd", 8'(rd[0]), 8'd0);
      chk("reset done", 8'(done[0]), 8'd0);
      reset = 1'b1;
      @(negedge clk);
      // single byte 8N1
      c0 = rd_cnt[0];
      rdat[0] = 8'hA5; empty[0] = 1'b0; en[0] = 1'b1;
      run_frame(0, {1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'h00);
      chk("rd count single", 8'(rd_cnt[0] - c0), 8'd1);
      // back-to-back 0x00 then 0xFF
      c0 = rd_cnt[0];
      rdat[0] = 8'h00; empty[0] = 1'b0;
      run_frame(0, {1'b1, 8'h00, 1'b0}, 10, 1'b1, 8'hFF);
      run_frame(0, {1'b1, 8'hFF, 1'b0}, 10, 1'b0, 8'h00);
      chk("rd count b2b", 8'(rd_cnt[0] - c0), 8'd2);
      // en low with data available
      c0 = rd_cnt[0];
      en[0] = 1'b0; rdat[0] = 8'h55; empty[0] = 1'b0;
      repeat (10) @(negedge clk);
      chk("gated rd", 8'(rd_cnt[0] - c0), 8'd0);
      chk("gated tx", 8'(tx[0]), 8'd1);
      chk("gated busy", 8'(busy[0]), 8'd0);
      // empty FIFO
      en[0] = 1'b1; empty[0] = 1'b1;
      repeat (10) @(negedge clk);
      chk("empty rd", 8'(rd_cnt[0] - c0), 8'd0);
      chk("empty tx", 8'(tx[0]), 8'd1);
      // en drops mid-frame with a second word waiting
      rdat[0] = 8'h5A; empty[0] = 1'b0;
      #1 chk("endrop rd", 8'(rd[0]), 8'd1);
      @(posedge clk);
      #1 rdat[0] = 8'h11;
      repeat (10) @(negedge clk);
      en[0] = 1'b0;
      repeat (30) @(negedge clk);
      chk("endrop done", 8'(done[0]), 8'd1);
      chk("endrop rd end", 8'(rd[0]), 8'd0);
      repeat (6) @(negedge clk);
      chk("endrop busy", 8'(busy[0]), 8'd0);
      chk("endrop tx", 8'(tx[0]), 8'd1);
      chk("endrop rd count", 8'(rd_cnt[0] - c0), 8'd1);
      empty[0] = 1'b1; en[0] = 1'b1;
      // asynchronous reset during data bit 3 of 0xF0 (that bit is 0)
      @(negedge clk);
      rdat[0] = 8'hF0; empty[0] = 1'b0;
      #1 chk("rst rd", 8'(rd[0]), 8'd1);
      @(posedge clk);
      #1 empty[0] = 1'b1;
      repeat (18) @(negedge clk);
      chk("rst pre tx", 8'(tx[0]), 8'd0);
      #2 reset = 1'b0;
      #1;
      chk("rst async tx", 8'(tx[0]), 8'd1);
      chk("rst async busy", 8'(busy[0]), 8'd0);
      @(negedge clk);
      reset = 1'b1;
      rdat[0] = 8'h3C; empty[0] = 1'b0;
      run_frame(0, {1'b1, 8'h3C, 1'b0}, 10, 1'b0, 8'h00);
      // parity: 0x07 has three ones
      rdat[1] = 8'h07; empty[1] = 1'b0; en[1] = 1'b1;
      run_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 8'h00);
      rdat[2] = 8'h07; empty[2] = 1'b0; en[2] = 1'b1;
      run_frame(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 8'h00);
      // two stop bits
      rdat[3] = 8'h3C; empty[3] = 1'b0; en[3] = 1'b1;
      run_frame(3, {2'b11, 8'h3C, 1'b0}, 11, 1'b0, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the asymmetric FIFO's narrow read side.
- Pops one DATA_WIDTH word whenever the FIFO is non-empty and transmission is enabled, then serialises it as an asynchronous serial frame: start bit, data LSB first, optional parity, stop bit(s).
- Sits between the FIFO read port (rd, r_data, empty) and the board-level serial TX pin.

Parameters:
- DATA_WIDTH, 8: word width popped from the FIFO and number of data bits per frame.
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be at least 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: applies only when PARITY_EN=1. 0 selects even parity, 1 selects odd parity.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  permits starting new frames.
- empty  input  1  FIFO empty flag.
- r_data  input  DATA_WIDTH  FIFO head word, valid whenever empty=0 (first-word fall-through).
- rd  output  1  FIFO pop strobe, one cycle per word.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- done_tick  output  1  one-cycle pulse in the final cycle of each frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; bit counter, tick counter and shift register clear.
  - tx=1, busy=0, rd=0, done_tick=0.
  - A frame in progress is abandoned and its word is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: load = en & ~empty & (state==IDLE | last cycle of the last stop bit).
  - rd = load, combinational, never more than one cycle per word.
  - On the same rising edge the shift register captures r_data and the state goes to START.
- Bit timing:
  - The tick counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - On the wrap the machine advances to the next bit or state.
  - Every bit is exactly CLKS_PER_BIT cycles long.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - tx = shift register bit 0; the register shifts right at each bit boundary.
  - A bit counter counts 0..DATA_WIDTH-1.
  - After DATA_WIDTH bits: go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: tx = XOR-reduction of the captured word, XOR PARITY_ODD. One bit time.
- STOP:
  - tx=1 for STOP_BITS bit times.
  - done_tick=1 in the final cycle.
  - Next state is START if load is true in that cycle (back-to-back frames, no idle gap), otherwise IDLE.
- busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- tx is driven from a register (glitch-free); tx=1 in IDLE.
- Frame length = CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles.
- en deasserted mid-frame: the current frame completes; no further pop occurs.
- FIFO empty: no rd is issued; the block waits in IDLE with tx=1.
- rd is never asserted while empty=1, so it is safe to connect directly to the FIFO rd input.
- Latency: tx falls one cycle after the rd cycle.

Test Plan:
- Single byte, 8N1: CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, en=1. FIFO holds 0xA5 -> rd high exactly 1 cycle; tx sequence is 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles; done_tick pulses at cycle 40 after rd; busy high for 40 cycles.
- Back-to-back: FIFO holds 0x00 then 0xFF -> second rd coincides with the first frame's done_tick; the second start bit follows the first stop bit with no gap; total 80 busy cycles; 2 rd pulses.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame length 44 cycles.
- Gating and empty: en=0 with FIFO non-empty -> rd stays 0 and tx stays 1. en drops mid-frame -> frame finishes, no further rd. empty=1 -> no rd.
- Reset mid-frame: assert reset low during DATA bit 3 -> tx=1 and busy=0 immediately, without waiting for a clock. After release with the FIFO holding 0x3C, the next frame starts cleanly and the old byte is not resumed.
- Two stop bits: STOP_BITS=2 -> stop phase is 8 cycles, frame length 44, done_tick only at the end of the second stop bit.
